// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I multi-cycle control slice:
// opcode constants, immediate/ALU/writeback/PC select codes,
// FSM state encoding, instruction classes and the EXEC-phase select helper.
package rv32i_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate generator select
  localparam logic [2:0] IMM_U = 3'd0;
  localparam logic [2:0] IMM_J = 3'd1;
  localparam logic [2:0] IMM_I = 3'd2;
  localparam logic [2:0] IMM_S = 3'd3;
  localparam logic [2:0] IMM_B = 3'd4;

  // ALU operand selects
  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;
  localparam logic       ALU_B_RS2  = 1'b0;
  localparam logic       ALU_B_IMM  = 1'b1;
  localparam logic [3:0] ALU_ADD    = 4'b0000;

  // Writeback and next-PC selects
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  typedef enum logic [2:0] {
    ST_BOOT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_ILL, CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC, CL_LOAD,
    CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_FENCE
  } iclass_t;

  // Operand/opcode selects that the FSM holds from EXEC through WB
  typedef struct packed {
    logic [1:0] a_sel;
    logic       b_sel;
    logic [3:0] alu_op;
  } exec_ctl_t;

  function automatic exec_ctl_t exec_ctl(iclass_t cls, logic [2:0] funct3, logic alt);
    exec_ctl_t e;
    e.a_sel  = ALU_A_RS1;
    e.b_sel  = ALU_B_RS2;
    e.alu_op = ALU_ADD;
    case (cls)
      CL_OP:     e.alu_op = {alt, funct3};
      CL_OPIMM: begin
        // Only the shift-right pair uses inst[30]; for the rest it is imm bits
        e.b_sel  = ALU_B_IMM;
        e.alu_op = {(funct3 == 3'b101) & alt, funct3};
      end
      CL_LUI: begin
        e.a_sel = ALU_A_ZERO;
        e.b_sel = ALU_B_IMM;
      end
      CL_AUIPC: begin
        e.a_sel = ALU_A_PC;
        e.b_sel = ALU_B_IMM;
      end
      CL_LOAD, CL_STORE, CL_JALR: e.b_sel = ALU_B_IMM;
      CL_BRANCH: e.alu_op = {1'b0, funct3};
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/rv32i_opdec.sv
// Purpose : opcode-to-class decoder (class, immediate format, legality).
// Latency : combinational.
// Backpr. : none; pure function of the opcode.
// Ports   : opcode (inst[6:0]) in; cls, imm_type, legal out.
module rv32i_opdec
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic [2:0] imm_type,
  output logic       legal
);

  always_comb begin
    cls      = CL_ILL;
    imm_type = IMM_I;
    case (opcode)
      OPC_LUI:    begin cls = CL_LUI;    imm_type = IMM_U; end
      OPC_AUIPC:  begin cls = CL_AUIPC;  imm_type = IMM_U; end
      OPC_JAL:    begin cls = CL_JAL;    imm_type = IMM_J; end
      OPC_JALR:   cls = CL_JALR;
      OPC_BRANCH: begin cls = CL_BRANCH; imm_type = IMM_B; end
      OPC_LOAD:   cls = CL_LOAD;
      OPC_STORE:  begin cls = CL_STORE;  imm_type = IMM_S; end
      OPC_OPIMM:  cls = CL_OPIMM;
      OPC_OP:     cls = CL_OP;
      OPC_FENCE:  cls = CL_FENCE;
      default:    cls = CL_ILL;   // includes SYSTEM: not supported, traps
    endcase
  end

  assign legal = (cls != CL_ILL);

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Purpose : multi-cycle RV32I control FSM (BOOT/FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Latency : zero-wait: branch 3, ALU/LUI/AUIPC/JAL/JALR/store 4, load 5, FENCE 2 cycles.
// Backpr. : imem_req/dmem_req held until the matching ack; optional timeout traps.
// Ports   : clk, rst_n; inst, imem_ack, dmem_ack, br_taken in;
//           imem_req, ir_we, dmem_req, dmem_we, imm_type, alu_a_sel, alu_b_sel,
//           alu_op, rf_we, wb_sel, pc_we, pc_sel, trap out.
// Option  : RV_ACK_TIMEOUT_EN adds an 8-bit ack wait counter (ACK_TIMEOUT cycles).
module rv32i_mc_ctrl
  import rv32i_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  imm_type,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap
);

  state_t    state, state_nxt;
  iclass_t   dec_cls, cls_q;
  logic [2:0] dec_imm, imm_q;
  logic       dec_legal;
  exec_ctl_t  dec_ex, ex_q;
  logic [3:0] boot_cnt;
  logic       ack_expired;

  rv32i_opdec u_opdec (
    .opcode   (inst[6:0]),
    .cls      (dec_cls),
    .imm_type (dec_imm),
    .legal    (dec_legal)
  );

  assign dec_ex = exec_ctl(dec_cls, inst[14:12], inst[30]);

  // Register-address and immediate fields belong to the datapath, not control
  logic unused_inst;
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

`ifdef RV_ACK_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // An ack on the final allowed cycle still wins: next-state checks ack first
  assign ack_expired = (wait_cnt == 8'(ACK_TIMEOUT - 1));

  // Cleared on every state change, so each FETCH/MEM visit starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if (state == ST_FETCH || state == ST_MEM) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_ack_timeout;
  assign unused_ack_timeout = 8'(ACK_TIMEOUT);
  assign ack_expired        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  // Boot hold counter and the decode snapshot held from EXEC through WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_cnt <= '0;
      cls_q    <= CL_ILL;
      imm_q    <= IMM_U;
      ex_q     <= '0;
    end else begin
      if (state == ST_BOOT) boot_cnt <= boot_cnt + 4'd1;
      if (state == ST_DECODE) begin
        cls_q <= dec_cls;
        imm_q <= dec_imm;
        ex_q  <= dec_ex;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      // The cycle in which rst_n rises is not counted, so BOOT exits on edge HOLD+1
      ST_BOOT:   if (boot_cnt == 4'(RESET_PC_HOLD)) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)         state_nxt = ST_DECODE;
        else if (ack_expired) state_nxt = ST_TRAP;
      end
      ST_DECODE: begin
        if (!dec_legal)             state_nxt = ST_TRAP;
        else if (dec_cls == CL_FENCE) state_nxt = ST_FETCH;
        else                        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls_q)
          CL_LOAD, CL_STORE: state_nxt = ST_MEM;
          CL_BRANCH:         state_nxt = ST_FETCH;
          default:           state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack)         state_nxt = (cls_q == CL_STORE) ? ST_FETCH : ST_WB;
        else if (ack_expired) state_nxt = ST_TRAP;
      end
      ST_WB:     state_nxt = ST_FETCH;
      ST_TRAP:   state_nxt = ST_TRAP;
      default:   state_nxt = ST_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    imm_type  = IMM_U;
    alu_a_sel = ALU_A_RS1;
    alu_b_sel = ALU_B_RS2;
    alu_op    = ALU_ADD;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    trap      = 1'b0;

    if (state == ST_EXEC || state == ST_MEM || state == ST_WB) begin
      imm_type  = imm_q;
      alu_a_sel = ex_q.a_sel;
      alu_b_sel = ex_q.b_sel;
      alu_op    = ex_q.alu_op;
    end

    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
      end
      ST_DECODE: begin
        // FENCE retires here as a NOP
        if (dec_cls == CL_FENCE) pc_we = 1'b1;
      end
      ST_EXEC: begin
        if (cls_q == CL_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = br_taken ? PC_IMM : PC_PLUS4;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CL_STORE);
        if (dmem_ack && cls_q == CL_STORE) pc_we = 1'b1;
      end
      ST_WB: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        case (cls_q)
          CL_LOAD: wb_sel = WB_MEM;
          CL_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          CL_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_ALU;
          end
          default: ;
        endcase
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Bench for rv32i_mc_ctrl: directed scenarios plus randomized instruction
// streams with random ack wait states, checked against a per-instruction
// expectation table derived from the control behaviour.
module tb_rv32i_mc_ctrl;

  localparam int HOLD = 3;
  localparam int TMO  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
  logic        imem_req, ir_we, dmem_req, dmem_we, alu_b_sel, rf_we, pc_we, trap;
  logic [2:0]  imm_type;
  logic [1:0]  alu_a_sel, wb_sel, pc_sel;
  logic [3:0]  alu_op;
  logic [20:0] outs;

  rv32i_mc_ctrl #(.RESET_PC_HOLD(HOLD), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .imm_type(imm_type), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_op(alu_op), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
    .trap(trap)
  );

  assign outs = {imem_req, ir_we, dmem_req, dmem_we, imm_type, alu_a_sel, alu_b_sel,
                 alu_op, rf_we, wb_sel, pc_we, pc_sel, trap};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from one instruction
  int         obs_lat, obs_pcwe, obs_rfwe, obs_same, obs_dreq, obs_ir;
  logic [1:0] obs_pcsel, obs_wbsel, obs_a;
  logic [2:0] obs_imm, obs_imm_wb;
  logic       obs_b, obs_dwe, obs_trap, obs_timeout;
  logic [3:0] obs_op;

  // Expectations from the reference table
  int         exp_lat, exp_rf, exp_dreq;
  logic [1:0] exp_pcsel, exp_wbsel, exp_a;
  logic [2:0] exp_imm;
  logic       exp_b, exp_dwe, exp_chk_exec, exp_chk_alu;
  logic [3:0] exp_op;

  function automatic logic [6:0] pick_op(input int k);
    case (k)
      0: return 7'h37; 1: return 7'h17; 2: return 7'h33; 3: return 7'h13;
      4: return 7'h03; 5: return 7'h23; 6: return 7'h63; 7: return 7'h6F;
      8: return 7'h67; default: return 7'h0F;
    endcase
  endfunction

  // Expected behaviour per opcode: zero-wait latency plus wait states.
  task automatic model(input logic [31:0] w, input int iw, input int dw, input logic br);
    logic [2:0] f3;
    logic       alt;
    int         base;
    f3 = w[14:12];
    alt = w[30];
    base = 4; exp_rf = 1; exp_dreq = 0; exp_dwe = 1'b0;
    exp_pcsel = 2'd0; exp_wbsel = 2'd0; exp_imm = 3'd2;
    exp_a = 2'd0; exp_b = 1'b1; exp_op = 4'd0;
    exp_chk_exec = 1'b1; exp_chk_alu = 1'b1;
    case (w[6:0])
      7'h37: begin exp_imm = 3'd0; exp_a = 2'd2; end
      7'h17: begin exp_imm = 3'd0; exp_a = 2'd1; end
      7'h33: begin exp_b = 1'b0; exp_op = {alt, f3}; end
      7'h13: exp_op = {(f3 == 3'd5) ? alt : 1'b0, f3};
      7'h03: begin base = 5 + dw; exp_wbsel = 2'd1; exp_dreq = dw + 1; end
      7'h23: begin base = 4 + dw; exp_rf = 0; exp_imm = 3'd3; exp_dreq = dw + 1; exp_dwe = 1'b1; end
      7'h63: begin base = 3; exp_rf = 0; exp_imm = 3'd4; exp_b = 1'b0;
                   exp_op = {1'b0, f3}; exp_pcsel = br ? 2'd1 : 2'd0; end
      7'h6F: begin exp_imm = 3'd1; exp_wbsel = 2'd2; exp_pcsel = 2'd1; exp_chk_alu = 1'b0; end
      7'h67: begin exp_wbsel = 2'd2; exp_pcsel = 2'd2; end
      default: begin base = 2; exp_rf = 0; exp_chk_exec = 1'b0; exp_chk_alu = 1'b0; end
    endcase
    exp_lat = base + iw;
  endtask

  // Entered at a negedge with the DUT in FETCH; returns at the negedge where the next FETCH starts.
  task automatic run_instr(input logic [31:0] w, input int iw, input int dw, input logic br);
    int cyc, fc, dc;
    bit ir_seen;
    cyc = 0; fc = 0; dc = 0; ir_seen = 0;
    inst = w; br_taken = br;
    obs_pcwe = 0; obs_rfwe = 0; obs_same = 0; obs_dreq = 0; obs_ir = 0;
    obs_pcsel = 2'd3; obs_wbsel = 2'd3; obs_dwe = 1'b0; obs_trap = 1'b0; obs_timeout = 1'b0;
    obs_imm = 3'd7; obs_imm_wb = 3'd7; obs_a = 2'd3; obs_b = 1'bx; obs_op = 4'hF;
    while (1'b1) begin
      if (cyc > 0 && imem_req && ir_seen) break;
      if (cyc >= 300) begin obs_timeout = 1'b1; break; end
      // acks outside FETCH/MEM are random noise the DUT must ignore
      if (imem_req) begin imem_ack = (fc == iw); fc++; end
      else imem_ack = 1'($urandom_range(0, 1));
      if (dmem_req) begin dmem_ack = (dc == dw); dc++; end
      else dmem_ack = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (ir_we) begin obs_ir++; ir_seen = 1; end
      if (pc_we) begin obs_pcwe++; obs_pcsel = pc_sel; obs_imm_wb = imm_type; end
      if (rf_we) begin obs_rfwe++; obs_wbsel = wb_sel; if (pc_we) obs_same++; end
      if (dmem_req) begin obs_dreq++; obs_dwe = obs_dwe | dmem_we; end
      if (trap) obs_trap = 1'b1;
      if (cyc == iw + 3) begin
        obs_imm = imm_type; obs_a = alu_a_sel; obs_b = alu_b_sel; obs_op = alu_op;
      end
      @(negedge clk);
    end
    obs_lat = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD + 1) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int cnt;
    bit mem_seen;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (outs !== 21'd0) $display("FAIL reset_outs got %h exp 0", outs); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1; cnt = i;
      if (imem_req) break;
    end
    n_checks++; if (cnt !== HOLD + 1 || !imem_req) $display("FAIL boot_hold got %0d exp %0d", cnt, HOLD + 1); else n_pass++;
    // Walk an LW into MEM with no dmem_ack, then reset mid-access
    @(negedge clk);
    inst = 32'h0040A103;
    mem_seen = 0;
    for (int k = 0; k < 10; k++) begin
      imem_ack = imem_req; dmem_ack = 1'b0; #1;
      if (dmem_req) begin mem_seen = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (mem_seen !== 1'b1) $display("FAIL reach_mem got %0d exp 1", mem_seen); else n_pass++;
    #2; rst_n = 1'b0; imem_ack = 1'b0; #1;
    n_checks++; if (dmem_req !== 1'b0) $display("FAIL async_drop got %b exp 0", dmem_req); else n_pass++;
    n_checks++; if (outs !== 21'd0) $display("FAIL async_outs got %h exp 0", outs); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1; cnt = i;
      if (imem_req) break;
    end
    n_checks++; if (cnt !== HOLD + 1 || !imem_req) $display("FAIL reboot_hold got %0d exp %0d", cnt, HOLD + 1); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_addi();
    run_instr(32'h00500093, 0, 0, 1'b0);
    n_checks++; if (obs_lat !== 4) $display("FAIL addi_lat got %0d exp 4", obs_lat); else n_pass++;
    n_checks++; if (obs_imm !== 3'd2) $display("FAIL addi_imm got %0d exp 2", obs_imm); else n_pass++;
    n_checks++; if (obs_b !== 1'b1) $display("FAIL addi_bsel got %b exp 1", obs_b); else n_pass++;
    n_checks++; if (obs_op !== 4'd0) $display("FAIL addi_op got %h exp 0", obs_op); else n_pass++;
    n_checks++; if (obs_same !== 1 || obs_pcwe !== 1 || obs_pcsel !== 2'd0)
      $display("FAIL addi_wb got same=%0d pcwe=%0d pcsel=%0d exp 1/1/0", obs_same, obs_pcwe, obs_pcsel); else n_pass++;
  endtask

  task automatic test_load_wait();
    run_instr(32'h0040A103, 0, 3, 1'b0);
    n_checks++; if (obs_lat !== 8) $display("FAIL lw_lat got %0d exp 8", obs_lat); else n_pass++;
    n_checks++; if (obs_dreq !== 4 || obs_dwe !== 1'b0)
      $display("FAIL lw_dmem got req=%0d we=%b exp 4/0", obs_dreq, obs_dwe); else n_pass++;
    n_checks++; if (obs_wbsel !== 2'd1 || obs_rfwe !== 1)
      $display("FAIL lw_wb got wbsel=%0d rfwe=%0d exp 1/1", obs_wbsel, obs_rfwe); else n_pass++;
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      run_instr(32'h00000463, 0, 0, 1'(t));
      n_checks++; if (obs_imm !== 3'd4) $display("FAIL beq_imm got %0d exp 4", obs_imm); else n_pass++;
      n_checks++; if (obs_pcwe !== 1 || obs_pcsel !== 2'(t))
        $display("FAIL beq_pc got pcwe=%0d pcsel=%0d exp 1/%0d", obs_pcwe, obs_pcsel, t); else n_pass++;
      n_checks++; if (obs_rfwe !== 0 || obs_lat !== 3)
        $display("FAIL beq_rf_lat got rfwe=%0d lat=%0d exp 0/3", obs_rfwe, obs_lat); else n_pass++;
    end
  endtask

  task automatic test_jalr();
    run_instr(32'h000280E7, 0, 0, 1'b0);
    n_checks++; if (obs_same !== 1 || obs_wbsel !== 2'd2 || obs_pcsel !== 2'd2)
      $display("FAIL jalr_wb got same=%0d wbsel=%0d pcsel=%0d exp 1/2/2", obs_same, obs_wbsel, obs_pcsel); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    int strobes;
    logic tr2, tr3;
    words[0] = 32'h0000007F;
    words[1] = 32'h00000073;
    for (int n = 0; n < 2; n++) begin
      inst = words[n]; strobes = 0; tr2 = 1'bx; tr3 = 1'bx;
      for (int c = 1; c <= 6; c++) begin
        imem_ack = imem_req ? 1'b1 : 1'($urandom_range(0, 1));
        dmem_ack = 1'($urandom_range(0, 1));
        #1;
        if (pc_we || rf_we) strobes++;
        if (c == 2) tr2 = trap;
        if (c == 3) tr3 = trap;
        @(negedge clk);
      end
      #1;
      n_checks++; if (tr2 !== 1'b0 || tr3 !== 1'b1) $display("FAIL ill_trap got %b%b exp 01", tr2, tr3); else n_pass++;
      n_checks++; if (strobes !== 0) $display("FAIL ill_strobes got %0d exp 0", strobes); else n_pass++;
      n_checks++; if (imem_req !== 1'b0 || trap !== 1'b1)
        $display("FAIL ill_sticky got req=%b trap=%b exp 0/1", imem_req, trap); else n_pass++;
      do_reset();
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int iw, dw;
    logic br;
    for (int n = 0; n < 60; n++) begin
      w = $urandom();
      w[6:0] = pick_op(int'($urandom_range(0, 9)));
      iw = int'($urandom_range(0, TMO - 1));
      dw = int'($urandom_range(0, TMO - 1));
      br = 1'($urandom_range(0, 1));
      model(w, iw, dw, br);
      run_instr(w, iw, dw, br);
      n_checks++; if (obs_timeout || obs_lat !== exp_lat)
        $display("FAIL rnd_lat inst=%h got %0d exp %0d", w, obs_lat, exp_lat); else n_pass++;
      n_checks++; if (obs_pcwe !== 1 || obs_pcsel !== exp_pcsel || obs_ir !== 1 || obs_trap !== 1'b0)
        $display("FAIL rnd_pc inst=%h got pcwe=%0d pcsel=%0d ir=%0d trap=%b exp 1/%0d/1/0",
                 w, obs_pcwe, obs_pcsel, obs_ir, obs_trap, exp_pcsel); else n_pass++;
      n_checks++; if (obs_rfwe !== exp_rf) $display("FAIL rnd_rfwe inst=%h got %0d exp %0d", w, obs_rfwe, exp_rf); else n_pass++;
      if (exp_rf == 1) begin
        n_checks++; if (obs_wbsel !== exp_wbsel || obs_same !== 1)
          $display("FAIL rnd_wb inst=%h got wbsel=%0d same=%0d exp %0d/1", w, obs_wbsel, obs_same, exp_wbsel); else n_pass++;
      end
      n_checks++; if (obs_dreq !== exp_dreq || obs_dwe !== exp_dwe)
        $display("FAIL rnd_dmem inst=%h got req=%0d we=%b exp %0d/%b", w, obs_dreq, obs_dwe, exp_dreq, exp_dwe); else n_pass++;
      if (exp_chk_exec) begin
        n_checks++; if (obs_imm !== exp_imm || obs_imm_wb !== exp_imm)
          $display("FAIL rnd_imm inst=%h got exec=%0d retire=%0d exp %0d", w, obs_imm, obs_imm_wb, exp_imm); else n_pass++;
      end
      if (exp_chk_alu) begin
        n_checks++; if (obs_a !== exp_a || obs_b !== exp_b || obs_op !== exp_op)
          $display("FAIL rnd_alu inst=%h got a=%0d b=%b op=%h exp a=%0d b=%b op=%h",
                   w, obs_a, obs_b, obs_op, exp_a, exp_b, exp_op); else n_pass++;
      end
    end
  endtask

`ifdef RV_ACK_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    inst = 32'h00500093;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (trap) break;
      if (imem_req) n++;
      @(negedge clk);
    end
    n_checks++; if (n !== TMO || trap !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL imem_timeout got cycles=%0d trap=%b req=%b exp %0d/1/0", n, trap, imem_req, TMO); else n_pass++;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_jalr();
    test_illegal();
    test_random();
`ifdef RV_ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. Sequences fetch/decode/execute/memory/writeback, drives the immediate generator's inst_type select, and issues ALU, register file, PC and memory strobes. Instruction and data memory use req/ack handshakes. Sits between the instruction register and the datapath muxes.

Parameters:
RESET_PC_HOLD, 1, cycles spent in BOOT after reset release before the first fetch (1..15)
ACK_TIMEOUT, 255, max wait cycles for imem_ack/dmem_ack (used only with RV_ACK_TIMEOUT_EN)

Ports:
clk  in  1  core clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
inst  in  32  instruction register contents (valid from DECODE onward)
imem_ack  in  1  instruction fetch complete; inst word on bus this cycle
dmem_ack  in  1  data access complete
br_taken  in  1  datapath comparator result for the current funct3
imem_req  out  1  instruction fetch request
ir_we  out  1  latch fetched word into IR
dmem_req  out  1  data request
dmem_we  out  1  1=store, 0=load
imm_type  out  3  immediate select: 0 U, 1 J, 2 I, 3 S, 4 B
alu_a_sel  out  2  0 rs1, 1 pc, 2 zero
alu_b_sel  out  1  0 rs2, 1 imm
alu_op  out  4  {alt, funct3}; 4'b0000 = ADD
rf_we  out  1  register file write
wb_sel  out  2  0 alu, 1 mem, 2 pc+4
pc_we  out  1  PC update
pc_sel  out  2  0 pc+4, 1 pc+imm, 2 alu result & ~1
trap  out  1  illegal instruction (or timeout); sticky

Behaviour:
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset: state=BOOT; all outputs 0; trap=0.
- Reset mid-operation: immediate return to BOOT; any pending req dropped asynchronously.
- BOOT: count RESET_PC_HOLD cycles, then go to FETCH.
- FETCH: imem_req=1 held until imem_ack. On ack: ir_we=1, next DECODE. No timeout unless the option is enabled.
- DECODE (1 cycle): decode opcode inst[6:0] and register imm_type:
  LUI/AUIPC=U, JAL=J, BRANCH=B, STORE=S, all others=I.
  Unknown opcode or SYSTEM: go to TRAP. FENCE: pc_we with pc_sel=0, then FETCH (NOP).
- EXEC (1 cycle). imm_type, alu_a_sel and alu_b_sel hold through WB.
  - OP: a=rs1, b=rs2, alu_op={inst[30],funct3}.
  - OP-IMM: b=imm; alt=inst[30] only when funct3=101, else 0.
  - LUI: a=zero, b=imm. AUIPC: a=pc, b=imm.
  - LOAD/STORE: a=rs1, b=imm, ADD; then MEM.
  - BRANCH: a=rs1, b=rs2, alu_op={0,funct3}; pc_we=1, pc_sel=br_taken?1:0; then FETCH.
  - JAL: then WB. JALR: a=rs1, b=imm, ADD; then WB.
- MEM: dmem_req=1, dmem_we=(STORE), held until dmem_ack.
  - On ack, store: pc_we, pc_sel=0, then FETCH.
  - On ack, load: go to WB.
- WB (1 cycle): rf_we=1 and pc_we=1 in the same cycle.
  - ALU ops: wb_sel=0, pc_sel=0. Load: wb_sel=1, pc_sel=0.
  - JAL: wb_sel=2, pc_sel=1. JALR: wb_sel=2, pc_sel=2.
  - Then FETCH.
- Latency with zero-wait ack (ack in first FETCH/MEM cycle): branch 3 cycles, ALU/LUI/AUIPC/JAL/JALR 4, store 4, load 5.
- Strobe rules: ir_we, rf_we, pc_we are single-cycle pulses. Exactly one pc_we per retired instruction. No pc_we/rf_we for trapped instructions.
- rd=x0 writes still assert rf_we; the register file discards them.
- TRAP: trap=1; all strobes 0; remain until reset.
- An ack arriving outside FETCH/MEM is ignored.

Optional Feature:
RV_ACK_TIMEOUT_EN
- Defined: 8-bit wait counter, cleared on entry to FETCH/MEM.
  - If the count reaches ACK_TIMEOUT without ack: drop req, go to TRAP.
  - An ack arriving on the timeout cycle wins.
- Undefined: no counter; waits indefinitely.

Decomposition:
- Shared package rv32i_pkg: opcode constants, imm_type codes (IMM_U..IMM_B), alu_a/b/wb/pc select codes, FSM state encoding.
- One natural sub-module: rv32i_opdec, a combinational opcode-to-class decoder (class, imm_type, legality) instantiated by the FSM.

Test Plan:
- Reset: rst_n=0 mid-MEM with dmem_req=1 -> dmem_req=0 immediately; all outputs 0; first imem_req exactly RESET_PC_HOLD+1 cycles after rst_n rises.
- ADDI x1,x0,5 (0x00500093), zero-wait ack -> imm_type=2, alu_b_sel=1, alu_op=0000; rf_we and pc_we (pc_sel=0) in cycle 4; next imem_req in cycle 5.
- LW x2,4(x1) (0x0040A103), dmem_ack after 3 wait cycles -> dmem_we=0 held 4 cycles; WB wb_sel=1; total 8 cycles.
- BEQ (0x00000463) with br_taken=1, then br_taken=0 -> imm_type=4; pc_we with pc_sel=1, then pc_sel=0; rf_we never asserted.
- JALR x1,0(x5) (0x000280E7) -> WB: rf_we=1, wb_sel=2, pc_sel=2 in the same cycle.
- Opcode 0x0000007F -> trap=1 after DECODE; no pc_we/rf_we. With RV_ACK_TIMEOUT_EN and ACK_TIMEOUT=4, imem_ack withheld -> trap asserted after 4 FETCH cycles.
